// File: rtl/spi_slave_rx.sv
// Mode-0 SPI slave receiver: rebuilds a DATA_W-bit count from an LSB-then-MSB
// two-byte frame, range-checks it, and echoes the first byte on MISO during the second.
module spi_slave_rx #(
    parameter int unsigned DATA_W      = 14,
    parameter int unsigned MAX_VALUE   = 9999,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SCLK,
    input  logic              MOSI,
    input  logic              SS_n,
    output logic              MISO,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int unsigned MSB_W = DATA_W - 8;
    localparam logic [DATA_W-1:0] MAX_V = DATA_W'(MAX_VALUE);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RX_LSB   = 2'd1,
        RX_MSB   = 2'd2,
        WAIT_END = 2'd3
    } state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ss_sync_q;
    logic                   sclk_prev_q;
    logic                   sclk_s, mosi_s, ss_s, ss_next;
    logic                   rise, fall;

    state_e              state_q, state_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          rx_q, rx_d;
    logic [7:0]          lsb_q, lsb_d;
    logic [7:0]          tx_q, tx_d;
    logic                extra_q, extra_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                miso_q, miso_d;

    logic [7:0]          rx_shift;
    logic [DATA_W-1:0]   value;
    logic                value_ok;

    // Input synchronizers; SS_n chain resets to the deselected level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '1;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS_n};
            sclk_prev_q <= sclk_s;
        end
    end

    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
    assign ss_s    = ss_sync_q[SYNC_STAGES-1];
    assign ss_next = ss_sync_q[SYNC_STAGES-2];
    assign rise    = sclk_s & ~sclk_prev_q;
    assign fall    = ~sclk_s & sclk_prev_q;

    assign rx_shift = {rx_q[6:0], mosi_s};
    assign value    = {rx_shift[MSB_W-1:0], lsb_q};
    assign value_ok = ((rx_shift >> MSB_W) == 8'd0) && (value <= MAX_V);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            rx_q      <= 8'h00;
            lsb_q     <= 8'h00;
            tx_q      <= 8'h00;
            extra_q   <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            miso_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            lsb_q     <= lsb_d;
            tx_q      <= tx_d;
            extra_q   <= extra_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            miso_q    <= miso_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        lsb_d     = lsb_q;
        tx_d      = tx_q;
        extra_d   = extra_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                extra_d = 1'b0;
                if (!ss_s) begin
                    state_d   = RX_LSB;
                    bit_cnt_d = 3'd0;
                    tx_d      = 8'h00;
                end
            end
            RX_LSB: begin
                if (ss_s) begin
                    err_d   = (bit_cnt_q != 3'd0);
                    state_d = IDLE;
                end else if (rise) begin
                    rx_d = rx_shift;
                    if (bit_cnt_q == 3'd7) begin
                        lsb_d     = rx_shift;
                        tx_d      = rx_shift;
                        bit_cnt_d = 3'd0;
                        state_d   = RX_MSB;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else if (fall) begin
                    tx_d = {tx_q[6:0], 1'b0};
                end
            end
            RX_MSB: begin
                if (ss_s) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (rise) begin
                    rx_d = rx_shift;
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = 3'd0;
                        state_d   = WAIT_END;
                        if (value_ok) begin
                            data_d  = value;
                            valid_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                // The fall right after the load keeps echo bit 7 on MISO for the first rise
                end else if (fall && (bit_cnt_q != 3'd0)) begin
                    tx_d = {tx_q[6:0], 1'b0};
                end
            end
            WAIT_END: begin
                if (ss_s) begin
                    err_d   = extra_q;
                    extra_d = 1'b0;
                    state_d = IDLE;
                end else if (rise) begin
                    extra_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        miso_d = ss_next ? 1'b0 : tx_d[7];
    end

    assign MISO       = miso_q;
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: drives directed and random SPI frames and checks strobes,
// data_out, MISO echo and busy against a frame-level expectation queue.
module tb_spi_slave_rx;

    localparam int unsigned DATA_W      = 14;
    localparam int unsigned MAX_VALUE   = 9999;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int          HALF        = 4;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              SCLK  = 1'b0;
    logic              MOSI  = 1'b0;
    logic              SS_n  = 1'b1;
    logic              MISO;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              frame_err;
    logic              busy;

    spi_slave_rx #(
        .DATA_W     (DATA_W),
        .MAX_VALUE  (MAX_VALUE),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .SS_n      (SS_n),
        .MISO      (MISO),
        .data_out  (data_out),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        bit is_err;
        int val;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks    = 0;
    int  n_fail      = 0;
    int  model_dout  = 0;
    int  n_valid_seen = 0;
    int  n_err_seen   = 0;
    bit  rst_was_low  = 1'b0;
    ev_t cur;
    int  lat;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic bit frame_ok(input logic [7:0] lo, input logic [7:0] hi);
        int full;
        full = int'(hi) * 256 + int'(lo);
        return ((int'(hi) >> (DATA_W - 8)) == 0) && (full <= int'(MAX_VALUE));
    endfunction

    task automatic push_ev(input bit is_err, input int val);
        ev_t e;
        e.is_err = is_err;
        e.val    = val;
        e.cyc    = cycle;
        exp_q.push_back(e);
    endtask

    // Compare process: every strobe must match the next expected frame outcome
    always @(negedge clk) begin
        if (!rst_n) begin
            if (rst_was_low)
                check("reset_outputs", {MISO, data_out, data_valid, frame_err, busy}, 0);
            rst_was_low = 1'b1;
        end else begin
            rst_was_low = 1'b0;
            if (data_valid) n_valid_seen++;
            if (frame_err)  n_err_seen++;
            if (data_valid || frame_err) begin
                check("strobe_exclusive", data_valid & frame_err, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {data_valid, frame_err}, 0);
                end else begin
                    cur = exp_q.pop_front();
                    check("strobe_kind_err", frame_err, cur.is_err);
                    lat = cycle - cur.cyc;
                    check("strobe_latency", lat, SYNC_STAGES + 1);
                    if (!cur.is_err) model_dout = cur.val;
                end
            end
            check("data_out", data_out, model_dout);
        end
    end

    task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input int nbits, input bit reset_abort);
        logic [23:0] stream;
        stream = {b0, b1, b2};
        SS_n = 1'b0;
        tick(HALF);
        check("busy_in_frame", busy, 1);
        for (int i = 0; i < nbits; i++) begin
            MOSI = stream[23-i];
            tick(HALF);
            if (i < 8)       check("miso_byte0", MISO, 0);
            else if (i < 16) check("miso_byte1", MISO, b0[15-i]);
            SCLK = 1'b1;
            if (i == 15) push_ev(!frame_ok(b0, b1), int'(b1) * 256 + int'(b0));
            tick(HALF);
            SCLK = 1'b0;
        end
        tick(HALF);
        if (reset_abort) begin
            rst_n = 1'b0;
            exp_q.delete();
            model_dout = 0;
            tick(2);
            SS_n = 1'b1;
            tick(3);
            rst_n = 1'b1;
            tick(6);
            check("abort_data_out", data_out, 0);
            check("abort_busy", busy, 0);
        end else begin
            SS_n = 1'b1;
            if (nbits > 0 && nbits != 16) push_ev(1'b1, 0);
            tick(12);
            check("missed_strobe", exp_q.size(), 0);
            check("busy_after_frame", busy, 0);
            check("miso_deselected", MISO, 0);
        end
    endtask

    int v0, e0;

    initial begin
        // Reset held while the bus toggles
        for (int i = 0; i < 12; i++) begin
            SCLK = ~SCLK;
            MOSI = 1'($urandom_range(0, 1));
            tick(1);
        end
        SCLK = 1'b0;
        rst_n = 1'b1;
        tick(6);
        check("post_reset_busy", busy, 0);
        check("post_reset_data", data_out, 0);
        check("post_reset_strobes", n_valid_seen + n_err_seen, 0);

        run_frame(8'h34, 8'h12, 8'h00, 16, 1'b0);
        check("nominal_value", data_out, 'h1234);

        run_frame(8'h0F, 8'h27, 8'h00, 16, 1'b0);
        check("max_value", data_out, 9999);

        e0 = n_err_seen;
        run_frame(8'h10, 8'h27, 8'h00, 16, 1'b0);
        check("over_max_err", n_err_seen - e0, 1);
        check("over_max_hold", data_out, 9999);

        e0 = n_err_seen;
        run_frame(8'h00, 8'h40, 8'h00, 16, 1'b0);
        check("reserved_bit_err", n_err_seen - e0, 1);

        e0 = n_err_seen;
        run_frame(8'hA5, 8'h00, 8'h00, 5, 1'b0);
        check("truncated_err", n_err_seen - e0, 1);

        run_frame(8'h01, 8'h00, 8'h00, 16, 1'b0);
        check("after_trunc_value", data_out, 1);

        v0 = n_valid_seen; e0 = n_err_seen;
        run_frame(8'h00, 8'h00, 8'h00, 0, 1'b0);
        check("empty_select_strobes", (n_valid_seen - v0) + (n_err_seen - e0), 0);

        v0 = n_valid_seen; e0 = n_err_seen;
        run_frame(8'h05, 8'h00, 8'hFF, 24, 1'b0);
        check("overrun_valid", n_valid_seen - v0, 1);
        check("overrun_err", n_err_seen - e0, 1);
        check("overrun_value", data_out, 5);

        v0 = n_valid_seen; e0 = n_err_seen;
        run_frame(8'h77, 8'h00, 8'h00, 8, 1'b1);
        check("abort_strobes", (n_valid_seen - v0) + (n_err_seen - e0), 0);

        run_frame(8'h0A, 8'h00, 8'h00, 16, 1'b0);
        check("after_abort_value", data_out, 10);

        // Randomized frames: in-range values, raw bytes, truncations, overruns
        for (int f = 0; f < 40; f++) begin
            int kind, v, nb;
            logic [7:0] lo, hi, ex;
            kind = int'($urandom_range(0, 3));
            v    = int'($urandom_range(0, MAX_VALUE));
            lo   = 8'(v);
            hi   = 8'(v >> 8);
            ex   = 8'($urandom);
            nb   = 16;
            case (kind)
                1: begin lo = 8'($urandom); hi = 8'($urandom); end
                2: nb = int'($urandom_range(0, 15));
                3: nb = int'($urandom_range(17, 24));
                default: ;
            endcase
            run_frame(lo, hi, ex, nb, 1'b0);
        end

        tick(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
